noise_burst_ctrl: RTL
=====================

Name: noise_burst_ctrl

Overview:
Sequencer for the Gaussian noise summation stage and its output FIFO. On a trigger it clears the FIFO through the noise stage's reset, then issues SUM_START. It counts the noise stage's FIFO write strobes and issues SUM_STOP so that exactly NUM_SAMPLES words are written. It pauses and resumes generation on FIFO almost-full, and supports abort. It sits between the top-level pulse/timing logic and the noise summation block.

Parameters:
CNT_W, 16, width of sample count and write counter
CLR_CYCLES, 2, cycles NOISE_RST is held high per clear (min 1)

Ports:
CLK  in  1  system clock; all logic on posedge CLK
RESET  in  1  synchronous, active-high reset
TRIG  in  1  start a burst; sampled only in IDLE
NUM_SAMPLES  in  CNT_W  burst length in words; latched on accepted TRIG
ABORT  in  1  terminate burst and flush FIFO; level, sampled in CLEAR/START/RUN/PAUSE
FIFO_AFULL  in  1  FIFO almost-full; generation must pause
WR_MON  in  1  tap of noise stage FIFO_WR (registered there)
NOISE_RST  out  1  drives noise stage RESET (clears FIFO via its FIFO_SCLR)
SUM_START  out  1  one-cycle start request to noise stage
SUM_STOP  out  1  stop request to noise stage (Mealy, see below)
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse: burst completed with NUM_SAMPLES writes
ABORTED  out  1  one-cycle pulse: abort flush finished
TRIG_LOST  out  1  one-cycle pulse: TRIG seen while BUSY, or TRIG with NUM_SAMPLES==0
WR_COUNT  out  CNT_W  writes completed in current/last burst

Behaviour:
- Reset: state IDLE, all 1-bit outputs 0, WR_COUNT 0, target 0, abort flag 0. RESET mid-burst returns to IDLE in one cycle. No DONE or ABORTED pulse. The noise stage shares RESET, so the FIFO is also cleared.
- States: IDLE, CLEAR, START, RUN, PAUSE, FIN.
- IDLE: TRIG && NUM_SAMPLES!=0 -> latch target, WR_COUNT<=0, abort flag<=0, go CLEAR. TRIG && NUM_SAMPLES==0 -> TRIG_LOST, stay.
- CLEAR: NOISE_RST=1 for exactly CLR_CYCLES cycles (internal down-counter).
  - Abort flag 0: go START.
  - Abort flag 1: go IDLE and pulse ABORTED in the first IDLE cycle.
  - ABORT asserted during a normal clear: set abort flag and restart the clear count.
- START: SUM_START=1 for exactly this one cycle, then go RUN.
  - ABORT here: go CLEAR with flag set. SUM_START is still issued, so SUM_STOP=1 this cycle is not used; the noise stage reset clears it instead.
- RUN: each cycle WR_MON=1 -> WR_COUNT+1 (saturating never needed; target<=2^CNT_W-1).
- RUN, SUM_STOP combinational, high when any of:
  - (a) WR_MON && WR_COUNT==target-1 -> go FIN
  - (b) FIFO_AFULL -> go PAUSE
  - (c) ABORT -> go CLEAR with abort flag set
  - Priority c > a > b.
- Noise-stage timing contract:
  - START sampled at end of START cycle.
  - WR_MON first high two cycles after START state.
  - STOP sampled while WR_MON=1 still completes that cycle's write, then WR_MON falls.
  - Result: exactly target writes; N=1 works.
  - STOP before the first WR_MON produces zero writes.
- PAUSE: wait while FIFO_AFULL. On !FIFO_AFULL go START (re-issue start). ABORT -> CLEAR with flag. WR_COUNT holds.
- FIN: DONE=1 for one cycle, go IDLE. WR_COUNT holds the final value until the next accepted TRIG.
- TRIG in any non-IDLE state: TRIG_LOST pulse, burst unaffected.
- Latency: TRIG accepted at edge e0.
  - NOISE_RST high cycles 1..CLR_CYCLES.
  - START at cycle CLR_CYCLES+1.
  - First write at cycle CLR_CYCLES+3.
  - Uninterrupted burst: DONE at cycle CLR_CYCLES+3+N.

Decomposition:
- Shared package noise_pkg: state enum/localparams (IDLE..FIN), CNT_W default, CLR_CYCLES default.
- No sub-module needed; the clear down-counter stays inline. Reuse of noise_sum as the DUT partner in the bench is required for integration tests.

Test Plan:
- Basic burst: NUM_SAMPLES=10, TRIG 1 cycle, FIFO_AFULL=0 -> NOISE_RST high 2 cycles; SUM_START at cycle 3; exactly 10 WR_MON cycles; DONE at cycle 15; WR_COUNT=10.
- Single sample: NUM_SAMPLES=1 -> SUM_STOP high in the same cycle as the first WR_MON; exactly 1 write; DONE 1 cycle later.
- Back-pressure: NUM_SAMPLES=20, FIFO_AFULL high for 5 cycles after the 8th write -> SUM_STOP on AFULL; PAUSE; re-issued SUM_START after AFULL falls; total writes 20 (may include the write in the STOP cycle); DONE once.
- Abort mid-run: NUM_SAMPLES=100, ABORT at write 30 -> SUM_STOP that cycle; NOISE_RST high 2 cycles; ABORTED pulse; no DONE; WR_COUNT=30 or 31 per WR_MON that cycle.
- Trigger rules: TRIG with NUM_SAMPLES=0 -> TRIG_LOST, stays IDLE; TRIG during RUN -> TRIG_LOST, burst completes normally.
- Reset mid-PAUSE: RESET 1 cycle -> next cycle IDLE, all outputs 0, no DONE/ABORTED; new TRIG with NUM_SAMPLES=4 yields 4 writes.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared types and defaults for the noise burst sequencer.
package noise_pkg;

   localparam int CNT_W_DEF      = 16;
   localparam int CLR_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_START,
      ST_RUN,
      ST_PAUSE,
      ST_FIN
   } state_t;

endpackage

// File: rtl/noise_burst_ctrl.sv
// Burst sequencer for the Gaussian noise summation stage: clear FIFO, start,
// count writes, stop after exactly the requested count, pause on almost-full, abort.
module noise_burst_ctrl
   import noise_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             TRIG,
   input  logic [CNT_W-1:0] NUM_SAMPLES,
   input  logic             ABORT,
   input  logic             FIFO_AFULL,
   input  logic             WR_MON,
   output logic             NOISE_RST,
   output logic             SUM_START,
   output logic             SUM_STOP,
   output logic             BUSY,
   output logic             DONE,
   output logic             ABORTED,
   output logic             TRIG_LOST,
   output logic [CNT_W-1:0] WR_COUNT
);

   localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CLR_W-1:0] clr_cnt;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] wr_count;
   logic             abort_flg;
   logic             aborted_q;
   logic             trig_lost_q;
   logic             accept;
   logic             abort_go;
   logic             last_wr;

   assign last_wr = WR_MON && (wr_count == target - CNT_W'(1));

   always_comb begin
      state_nxt = state;
      SUM_STOP  = 1'b0;
      accept    = 1'b0;
      abort_go  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (TRIG && NUM_SAMPLES != '0) begin
               accept    = 1'b1;
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // A fresh abort during a normal clear restarts the clear window.
            if (ABORT && !abort_flg)
               abort_go = 1'b1;
            else if (clr_cnt == '0)
               state_nxt = abort_flg ? ST_IDLE : ST_START;
         end
         ST_START: begin
            // Start still goes out; the following clear resets the noise stage.
            if (ABORT) begin
               abort_go  = 1'b1;
               state_nxt = ST_CLEAR;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ABORT) begin
               SUM_STOP  = 1'b1;
               abort_go  = 1'b1;
               state_nxt = ST_CLEAR;
            end else if (last_wr) begin
               SUM_STOP  = 1'b1;
               state_nxt = ST_FIN;
            end else if (FIFO_AFULL) begin
               SUM_STOP  = 1'b1;
               state_nxt = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (ABORT) begin
               abort_go  = 1'b1;
               state_nxt = ST_CLEAR;
            end else if (!FIFO_AFULL) begin
               state_nxt = ST_START;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         clr_cnt     <= '0;
         target      <= '0;
         wr_count    <= '0;
         abort_flg   <= 1'b0;
         aborted_q   <= 1'b0;
         trig_lost_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         trig_lost_q <= TRIG && (state != ST_IDLE || NUM_SAMPLES == '0);
         aborted_q   <= (state == ST_CLEAR) && (state_nxt == ST_IDLE);
         if (accept) begin
            target    <= NUM_SAMPLES;
            wr_count  <= '0;
            abort_flg <= 1'b0;
            clr_cnt   <= CLR_LOAD;
         end else begin
            if (abort_go) begin
               abort_flg <= 1'b1;
               clr_cnt   <= CLR_LOAD;
            end else if (state == ST_CLEAR && clr_cnt != '0) begin
               clr_cnt <= clr_cnt - CLR_W'(1);
            end
            if (state == ST_RUN && WR_MON)
               wr_count <= wr_count + CNT_W'(1);
         end
      end
   end

   assign NOISE_RST = (state == ST_CLEAR);
   assign SUM_START = (state == ST_START);
   assign BUSY      = (state != ST_IDLE);
   assign DONE      = (state == ST_FIN);
   assign ABORTED   = aborted_q;
   assign TRIG_LOST = trig_lost_q;
   assign WR_COUNT  = wr_count;

endmodule
